// File: rtl/ram_ps2.sv
// ram_ps2 -- 16 x 8 simple-dual-port RAM holding PS/2 quadrant values.
//
// One write port and one registered read port on a shared clock. The array
// is built from flops so that the whole contents, and q, clear
// asynchronously while rst_n is low.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset (clears q and every entry)
//   data       in   write data
//   wraddress  in   write address
//   wren       in   write enable, active high
//   rdaddress  in   read address, sampled every rising edge
//   q          out  registered read data (one cycle latency)
//
// Configuration macro:
//   RAM_PS2_WR_BYPASS_EN  defined   -> same-address read-during-write
//                                      returns the new data (write-first)
//                         undefined -> returns the old contents (read-first)

module ram_ps2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;

    // Read-side selection; the bypass only matters when both ports hit the
    // same entry on the same edge.
    always_comb begin
        rd_data = mem[rdaddress];
`ifdef RAM_PS2_WR_BYPASS_EN
        if (wren && (wraddress == rdaddress)) begin
            rd_data = data;
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wren) begin
            mem[wraddress] <= data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= rd_data;
        end
    end

endmodule

// File: tb/tb_ram_ps2.sv
// Directed testbench for ram_ps2. Inputs change 1 time unit after a rising
// edge; q is sampled 1 time unit after the edge it was registered on.
// The same-address collision expectation follows RAM_PS2_WR_BYPASS_EN.

module tb_ram_ps2;

    logic       clock;
    logic       rst_n;
    logic [7:0] data;
    logic [3:0] wraddress;
    logic       wren;
    logic [3:0] rdaddress;
    logic [7:0] q;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ram_ps2 #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .data     (data),
        .wraddress(wraddress),
        .wren     (wren),
        .rdaddress(rdaddress),
        .q        (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: q=%02h expected=%02h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        wren      = 1'b1;
        wraddress = a;
        data      = d;
        tick();
        wren      = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_collide;
`ifdef RAM_PS2_WR_BYPASS_EN
        exp_collide = 8'h22;
`else
        exp_collide = 8'h11;
`endif
        rst_n     = 1'b0;
        data      = '0;
        wraddress = '0;
        wren      = 1'b0;
        rdaddress = '0;

        #3;
        check("reset_q", q, 8'h00);
        @(negedge clock);
        rst_n = 1'b1;
        tick();

        // Quadrant store
        write_word(4'h8, 8'h08);
        rdaddress = 4'h8;
        tick();
        check("quadrant_store", q, 8'h08);

        // Write-enable low leaves entry 3 untouched
        wren      = 1'b0;
        data      = 8'hFF;
        wraddress = 4'h3;
        repeat (3) tick();
        rdaddress = 4'h3;
        tick();
        check("wren_low", q, 8'h00);

        // Fill and readback
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            rdaddress = 4'(i);
            tick();
            check($sformatf("readback_%0d", i), q, 8'(i));
        end

        // Same-address collision
        write_word(4'h5, 8'h11);
        wren      = 1'b1;
        wraddress = 4'h5;
        rdaddress = 4'h5;
        data      = 8'h22;
        tick();
        wren = 1'b0;
        check("collide_same_edge", q, exp_collide);
        tick();
        check("collide_after", q, 8'h22);

        // Different-address read and write in the same cycle
        wren      = 1'b1;
        wraddress = 4'h6;
        data      = 8'h33;
        rdaddress = 4'h5;
        tick();
        wren = 1'b0;
        check("indep_read", q, 8'h22);
        rdaddress = 4'h6;
        tick();
        check("indep_write", q, 8'h33);

        // Asynchronous reset mid-operation
        write_word(4'h8, 8'h0F);
        rdaddress = 4'h8;
        tick();
        check("preload_8", q, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_q", q, 8'h00);
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        check("after_reset_mem8", q, 8'h00);
        rdaddress = 4'h6;
        tick();
        check("after_reset_mem6", q, 8'h00);

        // Write suppressed while in reset
        rst_n     = 1'b0;
        wren      = 1'b1;
        data      = 8'hAA;
        wraddress = 4'h2;
        tick();
        check("in_reset_q", q, 8'h00);
        wren = 1'b0;
        @(negedge clock);
        rst_n     = 1'b1;
        rdaddress = 4'h2;
        tick();
        check("reset_write_lost", q, 8'h00);

        // First edge after release performs a normal write
        write_word(4'h2, 8'h5A);
        tick();
        check("post_release_write", q, 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
